md_sequencer: RTL and testbench
===============================

# md_sequencer

Sequencer for the shared multiply/divide resource of the pipelined CPU core. It accepts a one-cycle issue request from the EX stage and runs the operation for a fixed number of cycles. It then commits the result to the HI/LO registers and exposes `busy`/`busy_cnt` so the hazard unit can stall dependent MFHI/MFLO and further mult/div instructions. An issue squashed by an exception flush in the same cycle never starts.

## Interface
- `MULT_CYCLES`, default 5: cycles `busy` stays high for MULT/MULTU (must be 1..31).
- `DIV_CYCLES`, default 10: cycles `busy` stays high for DIV/DIVU (must be 1..31).

Ports:
- `clk` input 1: the single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `start` input 1: issue request, sampled on the rising edge.
- `op` input 3: operation select. 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op.
- `a` input 32: rs operand (already forwarded).
- `b` input 32: rt operand (already forwarded).
- `flush` input 1: exception/interrupt squash of the EX instruction. Qualifies `start` only.
- `busy` output 1: operation in progress.
- `busy_cnt` output 5: remaining cycles before commit; 0 when idle.
- `hi` output 32: architectural HI.
- `lo` output 32: architectural LO.

## Operation
- Accepted issue: `start & ~flush & ~busy` at a rising edge.
  - `start` while `busy` is ignored. The hazard unit must prevent this; the bench checks that it is harmlessly dropped.
  - `start & flush` is ignored entirely: no state change.
- States:
  - IDLE: `busy`=0, `busy_cnt`=0.
  - RUN: `busy`=1, `busy_cnt` counts down.
- IDLE -> RUN on an accepted MULT/MULTU/DIV/DIVU.
  - Result is computed from `a`/`b` at the accept edge and held in pending registers `p_hi`/`p_lo`.
  - Later changes to `a`/`b` have no effect.
  - `busy_cnt` is loaded with MULT_CYCLES or DIV_CYCLES.
- RUN: `busy_cnt` decrements each edge. On the edge where `busy_cnt`==1:
  - `hi`<=`p_hi`, `lo`<=`p_lo`;
  - `busy_cnt`<=0, state -> IDLE.
- MTHI/MTLO accepted in IDLE: `hi`<=`a` (MTHI) or `lo`<=`a` (MTLO) at that edge. No RUN state, `busy` stays 0. Ignored while busy.
- `flush` during RUN has no effect; an issued operation always completes.
- Arithmetic:
  - MULT: signed 32x32 -> 64, {hi,lo}.
  - MULTU: unsigned 32x32 -> 64, {hi,lo}.
  - DIV: lo = quotient truncated toward zero; hi = remainder with the sign of `a`.
  - DIVU: unsigned quotient and remainder.
  - DIV of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divide by zero (`b`==0, DIV or DIVU): still runs DIV_CYCLES with `busy` high, but `hi`/`lo` are left unchanged at commit.
- No-op codes 6/7: accepted but no state change.

## Timing
- Reset values, asynchronous: `busy`=0, `busy_cnt`=0, `hi`=0, `lo`=0, pending registers 0, state IDLE.
- Reset asserted mid-RUN aborts the operation. `hi`/`lo` return to 0, not to their prior values.
- Accept at edge k:
  - `busy`=1 and `busy_cnt`=N from just after edge k.
  - `busy_cnt`=N-j after edge k+j.
  - Commit and `busy` fall at edge k+N, so `busy` is high for exactly N cycles.
  - `hi`/`lo` show the new result from edge k+N onward.
- Back-to-back: a new `start` presented in the cycle after commit (busy=0) is accepted at edge k+N+1. A `start` presented in the same cycle as the commit edge (busy still 1) is dropped.
- MTHI/MTLO: 1-cycle latency, `hi`/`lo` updated at the accept edge.
- `hi`/`lo` are registered outputs, glitch-free. `busy` and `busy_cnt` are registered.

## Test plan
- Reset, then MULT at edge 1 with a=0xFFFFFFFE (-2), b=3 -> `busy` high for 5 cycles with `busy_cnt` 5,4,3,2,1 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA after edge 6; MULTU with the same operands gives hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 10 busy cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=0 -> 10 busy cycles, hi/lo unchanged. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- `start`+`flush` together with op=MULT, a=5, b=5 -> busy stays 0, hi/lo unchanged. `flush` at the 3rd RUN cycle of MULT 5x5 -> lo=25 still committed on schedule.
- MULT 2x3 in RUN; at cycle 2 assert `start` with MTLO a=0x1234 and with DIV 9/3 -> both dropped; lo=6, hi=0 at commit; busy falls after 5 cycles.
- MTHI a=0xDEADBEEF -> hi=0xDEADBEEF next edge with busy never high; then MTLO a=0x1 -> lo=1.
- MULT started, `reset` pulsed asynchronously mid-cycle at cycle 3 -> busy=0, busy_cnt=0, hi=lo=0 immediately; after release, DIVU 100/7 -> lo=14, hi=2 after 10 cycles.

Source files
------------

// File: rtl/md_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : md_sequencer
// Brief    : Multi-cycle MULT/DIV sequencer with HI/LO commit and busy count.
// Revision : 1.0
// ============================================================================
module md_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic [4:0]  busy_cnt,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] C_OP_MULT  = 3'd0;
    localparam logic [2:0] C_OP_MULTU = 3'd1;
    localparam logic [2:0] C_OP_DIV   = 3'd2;
    localparam logic [2:0] C_OP_DIVU  = 3'd3;
    localparam logic [2:0] C_OP_MTHI  = 3'd4;
    localparam logic [2:0] C_OP_MTLO  = 3'd5;

    localparam logic [4:0] C_MULT_CNT = 5'(MULT_CYCLES);
    localparam logic [4:0] C_DIV_CNT  = 5'(DIV_CYCLES);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] p_hi_q, p_hi_d;
    logic [31:0] p_lo_q, p_lo_d;
    logic        p_wr_q, p_wr_d;

    logic               w_accept;
    logic               w_div_zero;
    logic               w_div_ovf;
    logic signed [63:0] w_smul;
    logic [63:0]        w_umul;
    logic signed [31:0] w_sdiv_b;
    logic signed [31:0] w_squot;
    logic signed [31:0] w_srem;
    logic [31:0]        w_udiv_b;
    logic [31:0]        w_uquot;
    logic [31:0]        w_urem;

    assign w_accept   = start & ~flush & (state_q == ST_IDLE);
    assign w_div_zero = (b == 32'd0);
    assign w_div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    assign w_smul = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign w_umul = {32'd0, a} * {32'd0, b};

    // Divisor forced to 1 for b==0 (result discarded) and for the
    // 0x80000000/-1 overflow, where a/1 yields the required q=a, r=0.
    assign w_sdiv_b = (w_div_zero || w_div_ovf) ? 32'sd1 : $signed(b);
    assign w_squot  = $signed(a) / w_sdiv_b;
    assign w_srem   = $signed(a) % w_sdiv_b;
    assign w_udiv_b = w_div_zero ? 32'd1 : b;
    assign w_uquot  = a / w_udiv_b;
    assign w_urem   = a % w_udiv_b;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        p_hi_d  = p_hi_q;
        p_lo_d  = p_lo_q;
        p_wr_d  = p_wr_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    case (op)
                        C_OP_MULT: begin
                            p_hi_d  = w_smul[63:32];
                            p_lo_d  = w_smul[31:0];
                            p_wr_d  = 1'b1;
                            cnt_d   = C_MULT_CNT;
                            state_d = ST_RUN;
                        end
                        C_OP_MULTU: begin
                            p_hi_d  = w_umul[63:32];
                            p_lo_d  = w_umul[31:0];
                            p_wr_d  = 1'b1;
                            cnt_d   = C_MULT_CNT;
                            state_d = ST_RUN;
                        end
                        C_OP_DIV: begin
                            p_hi_d  = w_srem;
                            p_lo_d  = w_squot;
                            p_wr_d  = ~w_div_zero;
                            cnt_d   = C_DIV_CNT;
                            state_d = ST_RUN;
                        end
                        C_OP_DIVU: begin
                            p_hi_d  = w_urem;
                            p_lo_d  = w_uquot;
                            p_wr_d  = ~w_div_zero;
                            cnt_d   = C_DIV_CNT;
                            state_d = ST_RUN;
                        end
                        C_OP_MTHI: hi_d = a;
                        C_OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    if (p_wr_q) begin
                        hi_d = p_hi_q;
                        lo_d = p_lo_q;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            p_hi_q  <= 32'd0;
            p_lo_q  <= 32'd0;
            p_wr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            p_hi_q  <= p_hi_d;
            p_lo_q  <= p_lo_d;
            p_wr_q  <= p_wr_d;
        end
    end

    assign busy     = (state_q == ST_RUN);
    assign busy_cnt = cnt_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_md_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_md_sequencer
// Brief    : Scoreboard bench for md_sequencer; expectations keyed by edge number.
// Revision : 1.0
// ============================================================================
module tb_md_sequencer;

    localparam logic [2:0] C_MULT  = 3'd0;
    localparam logic [2:0] C_MULTU = 3'd1;
    localparam logic [2:0] C_DIV   = 3'd2;
    localparam logic [2:0] C_DIVU  = 3'd3;
    localparam logic [2:0] C_MTHI  = 3'd4;
    localparam logic [2:0] C_MTLO  = 3'd5;
    localparam logic [2:0] C_NOP   = 3'd6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        flush = 1'b0;
    logic        busy;
    logic [4:0]  busy_cnt;
    logic [31:0] hi;
    logic [31:0] lo;

    md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .flush    (flush),
        .busy     (busy),
        .busy_cnt (busy_cnt),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        string       name;
        logic        bsy;
        logic [4:0]  cnt;
        logic [31:0] h;
        logic [31:0] l;
    } exp_t;

    exp_t        sb[$];
    int          edge_n = 0;
    int          total = 0;
    int          bad = 0;
    logic        stim_done = 1'b0;
    logic        mon_done = 1'b0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    always @(posedge clk) edge_n <= edge_n + 1;

    function automatic void push(input int c, input string nm, input logic bs,
                                 input logic [4:0] cn, input logic [31:0] h,
                                 input logic [31:0] l);
        exp_t e;
        e.cyc = c; e.name = nm; e.bsy = bs; e.cnt = cn; e.h = h; e.l = l;
        sb.push_back(e);
    endfunction

    // Monitor: every expectation due at or before the current edge is checked
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= edge_n) begin
                total++;
                if (busy !== sb[i].bsy || busy_cnt !== sb[i].cnt ||
                    hi !== sb[i].h || lo !== sb[i].l) begin
                    bad++;
                    $display("FAIL %s edge=%0d got busy=%b cnt=%0d hi=%h lo=%h exp busy=%b cnt=%0d hi=%h lo=%h",
                             sb[i].name, edge_n, busy, busy_cnt, hi, lo,
                             sb[i].bsy, sb[i].cnt, sb[i].h, sb[i].l);
                end
                sb.delete(i);
            end
        end
        if (stim_done && !mon_done) begin
            total++;
            if (sb.size() != 0) begin
                bad++;
                $display("FAIL scoreboard_drain got %0d pending exp 0", sb.size());
            end
            mon_done <= 1'b1;
        end
    end

    // Multi-cycle op; smask/fmask bit j injects start/flush in RUN cycle j
    task automatic run_op(input logic [2:0] o, input logic [31:0] aa,
                          input logic [31:0] bb, input int n,
                          input logic [31:0] eh, input logic [31:0] el,
                          input string nm, input logic [31:0] smask,
                          input logic [31:0] fmask);
        int k;
        @(negedge clk);
        k = edge_n + 1;
        start = 1'b1; op = o; a = aa; b = bb;
        for (int j = 0; j < n; j++) push(k + j, nm, 1'b1, 5'(n - j), m_hi, m_lo);
        push(k + n, nm, 1'b0, 5'd0, eh, el);
        m_hi = eh; m_lo = el;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            if (smask[j]) begin
                start = 1'b1;
                if (j % 2 == 1) begin op = C_MTLO; a = 32'h1234; end
                else begin op = C_DIV; a = 32'd9; b = 32'd3; end
            end
            flush = fmask[j];
            @(posedge clk); #1;
            start = 1'b0; flush = 1'b0;
        end
    endtask

    // Single-issue that must never raise busy; checked for nchk edges
    task automatic one_shot(input logic [2:0] o, input logic [31:0] aa,
                            input logic [31:0] bb, input logic fl,
                            input logic [31:0] eh, input logic [31:0] el,
                            input string nm, input int nchk);
        int k;
        @(negedge clk);
        k = edge_n + 1;
        start = 1'b1; op = o; a = aa; b = bb; flush = fl;
        for (int j = 0; j < nchk; j++) push(k + j, nm, 1'b0, 5'd0, eh, el);
        m_hi = eh; m_lo = el;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0; a = $urandom;
        repeat (nchk - 1) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        push(1, "reset_state", 1'b0, 5'd0, 32'd0, 32'd0);
        push(2, "reset_state", 1'b0, 5'd0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        run_op(C_MULT,  32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult_neg", 0, 0);
        run_op(C_MULTU, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA, "multu", 0, 0);
        run_op(C_DIV,   32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg", 0, 0);
        run_op(C_DIVU,  32'd7, 32'd0, 10, m_hi, m_lo, "divu_by_zero", 0, 0);
        run_op(C_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000, "div_ovf", 0, 0);
        one_shot(C_MULT, 32'd5, 32'd5, 1'b1, m_hi, m_lo, "start_flush", 6);
        run_op(C_MULT,  32'd5, 32'd5, 5, 32'd0, 32'd25, "flush_in_run", 0, 32'h4);
        run_op(C_MULT,  32'd2, 32'd3, 5, 32'd0, 32'd6, "start_while_busy", 32'h16, 0);
        one_shot(C_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b0, 32'hDEAD_BEEF, m_lo, "mthi", 2);
        one_shot(C_MTLO, 32'h0000_0001, 32'd0, 1'b0, m_hi, 32'd1, "mtlo", 2);
        one_shot(C_NOP,  32'h5555_5555, 32'd1, 1'b0, m_hi, m_lo, "noop", 2);

        // Asynchronous reset in the third RUN cycle of a MULT
        @(negedge clk);
        k = edge_n + 1;
        start = 1'b1; op = C_MULT; a = 32'd7; b = 32'd9;
        push(k,     "reset_pre", 1'b1, 5'd5, m_hi, m_lo);
        push(k + 1, "reset_pre", 1'b1, 5'd4, m_hi, m_lo);
        push(k + 2, "reset_async", 1'b0, 5'd0, 32'd0, 32'd0);
        push(k + 3, "reset_after", 1'b0, 5'd0, 32'd0, 32'd0);
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        @(posedge clk); #1;

        run_op(C_DIVU, 32'd100, 32'd7, 10, 32'd2, 32'd14, "divu_after_reset", 0, 0);

        repeat (2) @(posedge clk);
        stim_done = 1'b1;
        for (int i = 0; i < 10 && !mon_done; i++) @(posedge clk);
        if (!mon_done) begin
            $display("FAIL monitor_finish got pending exp done");
            $fatal(1, "monitor did not finish");
        end
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
